// File: rtl/pit_arb_pkg.sv
// Shared types and default widths for the PIT memory port arbiter.
package pit_arb_pkg;

    localparam int DEF_ADDR_W    = 62;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_BURST_LEN = 1024;
    localparam int DEF_CNT_W     = 10;
    localparam int DEF_WDOG_CYC  = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_IN  = 2'd1,
        ST_GNT_OUT = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_IN  = 1'b0,
        REQ_OUT = 1'b1
    } req_id_t;

endpackage

// File: rtl/pit_port_arbiter_if.sv
// Bundle of requester, grant and memory-port signals around the PIT arbiter.
// master: the arbiter itself. slave: the requesters and the PIT RAM.
interface pit_port_arbiter_if
    import pit_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              in_req;
    logic [ADDR_W-1:0] in_addr;
    logic              in_valid;
    logic [DATA_W-1:0] in_wdata;
    logic              in_gnt;
    logic              in_done;
    logic              in_abort;

    logic              out_req;
    logic [ADDR_W-1:0] out_addr;
    logic              out_gnt;
    logic              out_rvalid;
    logic [DATA_W-1:0] out_rdata;
    logic              out_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  in_req, in_addr, in_valid, in_wdata,
        output in_gnt, in_done, in_abort,
        input  out_req, out_addr,
        output out_gnt, out_rvalid, out_rdata, out_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        output in_req, in_addr, in_valid, in_wdata,
        input  in_gnt, in_done, in_abort,
        output out_req, out_addr,
        input  out_gnt, out_rvalid, out_rdata, out_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/pit_arb_rr.sv
// Two-way round-robin picker: req[0]=IN, req[1]=OUT. On a tie the requester
// that did not win last time is chosen.
module pit_arb_rr
    import pit_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_winner,
    output logic       gnt_vld,
    output req_id_t    gnt_id
);

    // Pick a winner among the active requests.
    always_comb begin
        gnt_vld = |req;
        gnt_id  = REQ_IN;
        if (req == 2'b11) begin
            gnt_id = (last_winner == REQ_IN) ? REQ_OUT : REQ_IN;
        end else if (req[1]) begin
            gnt_id = REQ_OUT;
        end
    end

endmodule

// File: rtl/pit_port_arbiter.sv
// Shares the byte-wide PIT RAM port between the IN (write) and OUT (read)
// burst requesters, granting whole bursts of BURST_LEN beats round-robin.
// Optional feature macro: PIT_ARB_WDOG_EN enables the IN stall watchdog.
module pit_port_arbiter
    import pit_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int WDOG_CYC  = DEF_WDOG_CYC
) (
    input  logic               clk,
    input  logic               reset,
    pit_port_arbiter_if.master bus
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    arb_state_t        state, state_d;
    logic [CNT_W-1:0]  beat, beat_d;
    logic [ADDR_W-1:0] base, base_d;
    req_id_t           last_winner, last_d;
    logic              in_gnt_r, in_gnt_d;
    logic              out_gnt_r, out_gnt_d;
    logic              in_done_r, in_done_d;
    logic              out_done_r, out_done_d;
    logic              mem_en_r, mem_en_d;
    logic              mem_we_r, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_d;
    logic              rd_vld_p1;
    logic              rr_vld;
    req_id_t           rr_id;

`ifdef PIT_ARB_WDOG_EN
    localparam int               STALL_W    = $clog2(WDOG_CYC + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(WDOG_CYC - 1);
    logic [STALL_W-1:0] stall_cnt, stall_d;
    logic               in_abort_r, in_abort_d;
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYC != 0);
`endif

    pit_arb_rr u_rr (
        .req         ({bus.out_req, bus.in_req}),
        .last_winner (last_winner),
        .gnt_vld     (rr_vld),
        .gnt_id      (rr_id)
    );

    // Next-state and next-output decode; every output below is registered.
    always_comb begin
        state_d     = state;
        beat_d      = beat;
        base_d      = base;
        last_d      = last_winner;
        in_gnt_d    = in_gnt_r;
        out_gnt_d   = out_gnt_r;
        in_done_d   = 1'b0;
        out_done_d  = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_r;
        mem_wdata_d = mem_wdata_r;
`ifdef PIT_ARB_WDOG_EN
        stall_d     = stall_cnt;
        in_abort_d  = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (rr_vld) begin
                    beat_d = '0;
                    last_d = rr_id;
`ifdef PIT_ARB_WDOG_EN
                    stall_d = '0;
`endif
                    if (rr_id == REQ_IN) begin
                        state_d  = ST_GNT_IN;
                        in_gnt_d = 1'b1;
                        base_d   = bus.in_addr;
                    end else begin
                        // First read issues in the same cycle the grant shows.
                        state_d    = ST_GNT_OUT;
                        out_gnt_d  = 1'b1;
                        base_d     = bus.out_addr;
                        mem_en_d   = 1'b1;
                        mem_addr_d = bus.out_addr;
                    end
                end
            end
            ST_GNT_IN: begin
                if (bus.in_valid) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = base + ADDR_W'(beat);
                    mem_wdata_d = bus.in_wdata;
                    beat_d      = beat + CNT_W'(1);
`ifdef PIT_ARB_WDOG_EN
                    stall_d     = '0;
`endif
                    if (beat == LAST_BEAT) begin
                        state_d   = ST_RELEASE;
                        in_gnt_d  = 1'b0;
                        in_done_d = 1'b1;
                    end
                end
`ifdef PIT_ARB_WDOG_EN
                else if (stall_cnt == STALL_LAST) begin
                    state_d    = ST_RELEASE;
                    in_gnt_d   = 1'b0;
                    in_abort_d = 1'b1;
                end else begin
                    stall_d = stall_cnt + STALL_W'(1);
                end
`endif
            end
            ST_GNT_OUT: begin
                // beat is the index of the read on the port this cycle.
                if (beat == LAST_BEAT) begin
                    state_d    = ST_RELEASE;
                    out_gnt_d  = 1'b0;
                    out_done_d = 1'b1;
                end else begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = base + ADDR_W'(beat) + ADDR_W'(1);
                    beat_d     = beat + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset kills any burst in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            beat        <= '0;
            last_winner <= REQ_OUT;
            in_gnt_r    <= 1'b0;
            out_gnt_r   <= 1'b0;
            in_done_r   <= 1'b0;
            out_done_r  <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            rd_vld_p1   <= 1'b0;
        end else begin
            state       <= state_d;
            beat        <= beat_d;
            last_winner <= last_d;
            in_gnt_r    <= in_gnt_d;
            out_gnt_r   <= out_gnt_d;
            in_done_r   <= in_done_d;
            out_done_r  <= out_done_d;
            mem_en_r    <= mem_en_d;
            mem_we_r    <= mem_we_d;
            mem_addr_r  <= mem_addr_d;
            mem_wdata_r <= mem_wdata_d;
            // p1: read data returns one cycle after the read issue
            rd_vld_p1   <= mem_en_r & ~mem_we_r;
        end
    end

    // Burst base address; only meaningful while a grant is held.
    always_ff @(posedge clk) begin
        base <= base_d;
    end

`ifdef PIT_ARB_WDOG_EN
    // Consecutive IN stall cycles and the abort pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            in_abort_r <= 1'b0;
        end else begin
            stall_cnt  <= stall_d;
            in_abort_r <= in_abort_d;
        end
    end
    assign bus.in_abort = in_abort_r;
`else
    assign bus.in_abort = 1'b0;
`endif

    assign bus.in_gnt     = in_gnt_r;
    assign bus.in_done    = in_done_r;
    assign bus.out_gnt    = out_gnt_r;
    assign bus.out_done   = out_done_r;
    assign bus.out_rvalid = rd_vld_p1;
    assign bus.out_rdata  = bus.mem_rdata;
    assign bus.mem_en     = mem_en_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_pit_port_arbiter.sv
// Scoreboard bench for pit_port_arbiter: stimulus pushes expected grants,
// writes and reads into queues; a negedge monitor pops and compares.
module tb_pit_port_arbiter;
    import pit_arb_pkg::*;

    localparam int ADDR_W    = 62;
    localparam int DATA_W    = 8;
    localparam int BURST_LEN = 1024;
    localparam int CNT_W     = 10;
    localparam int WDOG_CYC  = 255;
    localparam int BUDGET    = 5000;
    localparam int STALL_LEN = 300;
`ifdef PIT_ARB_WDOG_EN
    localparam int EXP_ABORTS = 1;
`else
    localparam int EXP_ABORTS = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pit_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pit_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
        .CNT_W(CNT_W), .WDOG_CYC(WDOG_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // RAM model: read data is a fixed function of the address, one cycle late.
    function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    initial bus.mem_rdata = '0;
    always @(posedge clk) begin
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem_f(bus.mem_addr);
    end

    // Scoreboard queues
    logic [ADDR_W-1:0] q_wr_addr[$];
    logic [DATA_W-1:0] q_wr_data[$];
    bit                q_wr_last[$];
    logic [ADDR_W-1:0] q_rd_addr[$];
    logic [DATA_W-1:0] q_rd_data[$];
    bit                q_rd_last[$];
    bit                q_gnt[$];      // 0 = IN, 1 = OUT
    bit                m_last_out = 1'b1;

    bit   mon_en = 1'b0;
    int   cyc = 0, in_done_cnt = 0, out_done_cnt = 0, abort_cnt = 0, rd_cnt = 0;
    int   in_done_cyc = 0, out_rise_cyc = 0;
    logic prev_in_gnt = 1'b0, prev_out_gnt = 1'b0;

    // Monitor
    always @(negedge clk) begin
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        bit                el;
        cyc++;
        if (mon_en) begin
            if (bus.in_gnt && bus.out_gnt) fail_now("both_grants_high");
            if ((bus.in_gnt && !prev_in_gnt) || (bus.out_gnt && !prev_out_gnt)) begin
                if (bus.out_gnt) out_rise_cyc = cyc;
                if (q_gnt.size() == 0) fail_now("grant_unexpected");
                else check("grant_order", 64'(bus.out_gnt), 64'(q_gnt.pop_front()));
            end
            if (bus.mem_en && bus.mem_we) begin
                if (q_wr_addr.size() == 0) fail_now("write_unexpected");
                else begin
                    ea = q_wr_addr.pop_front();
                    ed = q_wr_data.pop_front();
                    el = q_wr_last.pop_front();
                    check("wr_addr", 64'(bus.mem_addr), 64'(ea));
                    check("wr_data", 64'(bus.mem_wdata), 64'(ed));
                    check("in_done_with_last_write", 64'(bus.in_done), 64'(el));
                end
            end else if (bus.in_done) fail_now("in_done_without_write");
            if (bus.mem_en && !bus.mem_we) begin
                if (q_rd_addr.size() == 0) fail_now("read_unexpected");
                else check("rd_addr", 64'(bus.mem_addr), 64'(q_rd_addr.pop_front()));
            end
            if (bus.out_rvalid) begin
                rd_cnt++;
                if (q_rd_data.size() == 0) fail_now("rvalid_unexpected");
                else begin
                    ed = q_rd_data.pop_front();
                    el = q_rd_last.pop_front();
                    check("rd_data", 64'(bus.out_rdata), 64'(ed));
                    check("out_done_with_last_rvalid", 64'(bus.out_done), 64'(el));
                end
            end else if (bus.out_done) fail_now("out_done_without_rvalid");
            if (bus.in_done) begin
                in_done_cnt++;
                in_done_cyc = cyc;
            end
            if (bus.out_done) out_done_cnt++;
            if (bus.in_abort) abort_cnt++;
        end
        prev_in_gnt  = bus.in_gnt;
        prev_out_gnt = bus.out_gnt;
    end

    // Reference arbitration: a lone requester wins; a tie goes to whoever
    // did not win last. Returns who is served first.
    task automatic expect_grants(input bit in_r, input bit out_r, output bit first);
        if (in_r && out_r) begin
            first = !m_last_out;
            q_gnt.push_back(first);
            q_gnt.push_back(!first);
            m_last_out = !first;
        end else begin
            first = out_r;
            q_gnt.push_back(first);
            m_last_out = out_r;
        end
    endtask

    task automatic push_out(input logic [ADDR_W-1:0] base);
        for (int i = 0; i < BURST_LEN; i++) begin
            q_rd_addr.push_back(base + ADDR_W'(i));
            q_rd_data.push_back(mem_f(base + ADDR_W'(i)));
            q_rd_last.push_back(i == BURST_LEN - 1);
        end
    endtask

    task automatic wait_in_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET && !ok; i++) begin
            @(negedge clk);
            if (bus.in_gnt) ok = 1'b1;
        end
        if (!ok) fail_now("in_gnt_timeout");
    endtask

    task automatic wait_out_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET && !ok; i++) begin
            @(negedge clk);
            if (bus.out_gnt) ok = 1'b1;
        end
        if (!ok) fail_now("out_gnt_timeout");
    endtask

    // mode 0: in_valid always, 1: toggling 1/0, 2: random.
    // stall_at >= 0: hold in_valid low STALL_LEN cycles once that many bytes went.
    task automatic drive_in(input logic [ADDR_W-1:0] base, input int mode, input int stall_at);
        int cnt = 0, stalled = 0, guard = 0;
        bit v;
        logic [DATA_W-1:0] d;
        while (cnt < BURST_LEN && guard < 20000) begin
`ifdef PIT_ARB_WDOG_EN
            if (stall_at == cnt && stalled >= STALL_LEN) break;
`endif
            if (stall_at == cnt && stalled < STALL_LEN) begin
                v = 1'b0;
                stalled++;
            end else begin
                case (mode)
                    0:       v = 1'b1;
                    1:       v = (guard % 2 == 0);
                    default: v = 1'($urandom_range(0, 1));
                endcase
            end
            d = DATA_W'($urandom);
            bus.in_valid = v;
            bus.in_wdata = d;
            if (v) begin
                q_wr_addr.push_back(base + ADDR_W'(cnt));
                q_wr_data.push_back(d);
                q_wr_last.push_back(cnt == BURST_LEN - 1);
                cnt++;
            end
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b0;
        if (guard >= 20000) fail_now("in_drive_timeout");
    endtask

    task automatic service_in(input logic [ADDR_W-1:0] base, input int mode);
        bit ok;
        wait_in_gnt(ok);
        bus.in_req = 1'b0;
        if (ok) drive_in(base, mode, -1);
    endtask

    task automatic service_out();
        bit ok;
        int od;
        od = out_done_cnt;
        wait_out_gnt(ok);
        bus.out_req = 1'b0;
        if (ok) begin
            for (int i = 0; i < 2 * BURST_LEN && out_done_cnt == od; i++) @(negedge clk);
            if (out_done_cnt == od) fail_now("out_done_timeout");
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, "_in_gnt"},     64'(bus.in_gnt),     64'(0));
        check({name, "_in_done"},    64'(bus.in_done),    64'(0));
        check({name, "_in_abort"},   64'(bus.in_abort),   64'(0));
        check({name, "_out_gnt"},    64'(bus.out_gnt),    64'(0));
        check({name, "_out_rvalid"}, 64'(bus.out_rvalid), 64'(0));
        check({name, "_out_done"},   64'(bus.out_done),   64'(0));
        check({name, "_mem_en"},     64'(bus.mem_en),     64'(0));
        check({name, "_mem_we"},     64'(bus.mem_we),     64'(0));
        check({name, "_mem_addr"},   64'(bus.mem_addr),   64'(0));
        check({name, "_mem_wdata"},  64'(bus.mem_wdata),  64'(0));
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        return ADDR_W'({$urandom, $urandom});
    endfunction

    initial begin
        #800000;
        $display("FAIL global_timeout");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        bit first;
        int n_done, rd_start;
        logic [ADDR_W-1:0] bi, bo;
        bus.in_req = 0; bus.in_addr = '0; bus.in_valid = 0; bus.in_wdata = '0;
        bus.out_req = 0; bus.out_addr = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;
        mon_en = 1'b1;

        // Simultaneous requests straight out of reset: IN first, then OUT.
        bi = rand_addr(); bo = rand_addr();
        expect_grants(1, 1, first);
        check("tie_after_reset_model", 64'(first), 64'(0));
        push_out(bo);
        bus.in_addr = bi; bus.out_addr = bo;
        bus.in_req = 1; bus.out_req = 1;
        service_in(bi, 0);
        service_out();
        check("out_gnt_gap_after_in_done", 64'(out_rise_cyc - in_done_cyc), 64'(2));
        check("out_done_count_t2", 64'(out_done_cnt), 64'(1));

        // IN alone at 0x100, in_valid solid; one dead cycle afterwards.
        n_done = in_done_cnt;
        expect_grants(1, 0, first);
        bus.in_addr = 62'h100; bus.in_req = 1;
        service_in(62'h100, 0);
        check("t1_in_gnt_released", 64'(bus.in_gnt), 64'(0));
        @(negedge clk);
        check("t1_dead_mem_en", 64'(bus.mem_en), 64'(0));
        check("t1_dead_out_gnt", 64'(bus.out_gnt), 64'(0));
        check("t1_in_done_once", 64'(in_done_cnt - n_done), 64'(1));

        // OUT burst wrapping past the top of the address space.
        expect_grants(0, 1, first);
        push_out(62'h3FFF_FFFF_FFFF_FFFE);
        bus.out_addr = 62'h3FFF_FFFF_FFFF_FFFE; bus.out_req = 1;
        service_out();

        // IN with in_valid toggling.
        n_done = in_done_cnt;
        bi = rand_addr();
        expect_grants(1, 0, first);
        bus.in_addr = bi; bus.in_req = 1;
        service_in(bi, 1);
        @(negedge clk);
        check("t4_in_done_once", 64'(in_done_cnt - n_done), 64'(1));

        // IN stalls at beat 10 while OUT waits.
        n_done = in_done_cnt;
        bi = rand_addr(); bo = rand_addr();
        expect_grants(1, 0, first);
        bus.in_addr = bi; bus.in_req = 1;
        wait_in_gnt(first);
        bus.in_req = 0;
        expect_grants(0, 1, first);
        push_out(bo);
        bus.out_addr = bo; bus.out_req = 1;
        drive_in(bi, 0, 10);
        service_out();
        check("t5_abort_count", 64'(abort_cnt), 64'(EXP_ABORTS));
        check("t5_in_done_count", 64'(in_done_cnt - n_done), 64'(1 - EXP_ABORTS));

        // Reset in the middle of an OUT burst.
        bo = rand_addr();
        expect_grants(0, 1, first);
        push_out(bo);
        bus.out_addr = bo; bus.out_req = 1;
        wait_out_gnt(first);
        bus.out_req = 0;
        rd_start = rd_cnt;
        for (int i = 0; i < BUDGET && rd_cnt < rd_start + 500; i++) @(negedge clk);
        if (rd_cnt < rd_start + 500) fail_now("t6_reads_timeout");
        #2;
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        check_quiet("reset_mid_burst");
        q_rd_addr.delete(); q_rd_data.delete(); q_rd_last.delete();
        q_gnt.delete();
        m_last_out = 1'b1;
        @(negedge clk);
        check_quiet("reset_held");
        reset = 1'b0;
        mon_en = 1'b1;
        bi = rand_addr(); bo = rand_addr();
        expect_grants(1, 1, first);
        check("tie_after_mid_reset_model", 64'(first), 64'(0));
        push_out(bo);
        bus.in_addr = bi; bus.out_addr = bo;
        bus.in_req = 1; bus.out_req = 1;
        service_in(bi, 2);
        service_out();

        // Randomized request patterns.
        for (int k = 0; k < 3; k++) begin
            int pat;
            pat = $urandom_range(0, 2);
            bi = rand_addr(); bo = rand_addr();
            bus.in_addr = bi; bus.out_addr = bo;
            if (pat == 0) begin
                expect_grants(1, 0, first);
                bus.in_req = 1;
                service_in(bi, 2);
            end else if (pat == 1) begin
                expect_grants(0, 1, first);
                push_out(bo);
                bus.out_req = 1;
                service_out();
            end else begin
                expect_grants(1, 1, first);
                push_out(bo);
                bus.in_req = 1; bus.out_req = 1;
                if (!first) begin
                    service_in(bi, 2);
                    service_out();
                end else begin
                    service_out();
                    service_in(bi, 2);
                end
            end
            repeat (3) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("left_writes", 64'(q_wr_addr.size()), 64'(0));
        check("left_reads", 64'(q_rd_addr.size()), 64'(0));
        check("left_rdata", 64'(q_rd_data.size()), 64'(0));
        check("left_grants", 64'(q_gnt.size()), 64'(0));
        check("abort_total", 64'(abort_cnt), 64'(EXP_ABORTS));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
